stream_vector_accum: RTL and testbench
======================================

// Module: stream_vector_accum
// PURPOSE
//  Column-reduction counterpart of the vector replay buffer: consumes a DIM1 x DIM2 row-major
//  stream of narrow Y_W signed elements and accumulates it element-wise into one DIM2-long
//  vector of X_W signed sums, then streams that vector out. Sits after the int8 datapath to
//  fold rows (bias-gradient / pooling sums) before re-quantisation. Accept and drain alternate.
// PARAMETERS
//  X_W          32    accumulator/output width (signed)
//  Y_W          8     input element width (signed); X_W > Y_W
//  MATRIXSIZE_W 24    width of DIM1/DIM2
//  MEM_DEPTH    4096  accumulator entries; DIM2 <= MEM_DEPTH; ADDR_W = $clog2(MEM_DEPTH)
// PORTS
//  clk        in   1             clock
//  rst        in   1             synchronous, active-high reset
//  in_tdata   in   Y_W           signed input element
//  in_tlast   in   1             producer end-of-matrix marker (cross-check only)
//  in_tvalid  in   1             AXIS valid
//  in_tready  out  1             AXIS ready
//  out_tdata  out  X_W           signed accumulated element
//  out_tlast  out  1             high on element DIM2-1 of the output vector
//  out_tvalid out  1             AXIS valid
//  out_tready in   1             AXIS ready
//  frame_err  out  1             1-cycle pulse: in_tlast disagrees with counters
//  DIM1       in   MATRIXSIZE_W  rows to fold (>=1); held stable per matrix
//  DIM2       in   MATRIXSIZE_W  vector length (1..MEM_DEPTH); held stable per matrix
// BEHAVIOUR
//  Reset: state=RESET; in_tready=0, out_tvalid=0, out_tlast=0, frame_err=0, out_tdata=0;
//   col/row counters=0. Next cycle -> ACC. rst mid-operation aborts; partial sums discarded.
//  FSM: RESET->ACC; ACC->FLUSH on handshake with col==DIM2-1 && row==DIM1-1;
//   FLUSH->OUT after pipeline write retires and first read data is registered;
//   OUT->ACC on out handshake with out_tlast.
//  ACC: in_tready=1 only in ACC. Handshake = in_tvalid&in_tready. Per handshake: col++,
//   col wraps to 0 at DIM2-1 and row++; row wraps to 0 at DIM1-1.
//  Read-modify-write pipeline, 1 stage: at handshake cycle t issue mem read at col; at t+1
//   write sum = (row==0 ? 0 : mem[col]) + sext(in_tdata) to col. Row 0 never reads old data.
//  Hazard: if write-stage address == read-stage address (DIM2==1, back-to-back), forward the
//   write-stage sum instead of mem output. No bubbles; full throughput 1 elem/cycle.
//  Arithmetic: sext Y_W->X_W, X_W two's-complement add, wrap on overflow (see SATURATE_EN).
//  frame_err: pulses at t+1 if in_tlast=1 on a non-final element, or in_tlast=0 on the final
//   element; counters alone decide matrix end (in_tlast never shortens/extends a frame).
//  Latency: final input handshake at cycle T -> out_tvalid first high at T+3.
//  OUT: reads addresses 0..DIM2-1 in order with prefetch of next address on handshake so
//   out_tdata advances every cycle while out_tready=1. out_tready=0 holds out_tdata,
//   out_tlast, out_tvalid stable. out_tlast = (rd addr==DIM2-1). Sums not cleared by read;
//   next matrix row 0 overwrites.
//  Simultaneity: input and output never active together; in_tready=0 in FLUSH/OUT.
//  DIM1==1: output equals sign-extended input row. DIM2==1: single-beat output, tlast=1.
// CONFIGURATION
//  SATURATE_EN defined: add result clamps to [-2^(X_W-1), 2^(X_W-1)-1]; per-element sticky,
//   clamped value is stored and later additions continue from it.
//  SATURATE_EN undefined: modular X_W wrap, no clamp logic.
// TESTING
//  DIM1=3,DIM2=4, rows {1,2,3,4},{10,20,30,40},{-1,-2,-3,-4} -> out {10,20,30,40}, tlast on 40.
//  DIM1=5,DIM2=1, inputs 127,127,127,-128,1 back-to-back -> single beat 254, tlast=1 (forwarding).
//  DIM1=2,DIM2=3, out_tready toggled 1,0,0,1,... -> data held during stalls, exactly 3 beats.
//  Two matrices back-to-back (DIM1=2,DIM2=2: {1,1},{1,1} then {5,6},{7,8}) -> {2,2} then {12,14}.
//  in_tlast on element 2 of 4 (DIM1=1,DIM2=4) -> frame_err pulse once, output still 4 beats.
//  X_W=9: DIM1=4 of 127 -> 508 wraps to -4 without SATURATE_EN; 255 with SATURATE_EN.
//  rst asserted mid-ACC -> in_tready=0 next cycle, no output; fresh matrix afterwards correct.

Source files
------------

// File: rtl/stream_vector_accum.sv
// Folds a DIM1 x DIM2 row-major stream of signed elements into one DIM2-long vector of sums,
// then streams it out. Define SATURATE_EN to clamp the sums instead of wrapping them.
module stream_vector_accum #(
    parameter int X_W          = 32,
    parameter int Y_W          = 8,
    parameter int MATRIXSIZE_W = 24,
    parameter int MEM_DEPTH    = 4096,
    localparam int ADDR_W      = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [Y_W-1:0]          in_tdata,
    input  logic                    in_tlast,
    input  logic                    in_tvalid,
    output logic                    in_tready,
    output logic [X_W-1:0]          out_tdata,
    output logic                    out_tlast,
    output logic                    out_tvalid,
    input  logic                    out_tready,
    output logic                    frame_err,
    input  logic [MATRIXSIZE_W-1:0] DIM1,
    input  logic [MATRIXSIZE_W-1:0] DIM2
);
    typedef enum logic [1:0] {S_RESET, S_ACC, S_FLUSH, S_OUT} state_t;

    state_t                  state_q, state_d;
    logic                    flush_q, flush_d;
    logic [MATRIXSIZE_W-1:0] col_q, col_d, row_q, row_d, out_addr_q, out_addr_d;
    logic                    hs, last_elem, rd_en;
    logic [ADDR_W-1:0]       rd_addr;

    logic [X_W-1:0]          mem [MEM_DEPTH];
    logic [X_W-1:0]          rd_q, wr_x_q, fwd_data_q, old_val, sum;
    logic [ADDR_W-1:0]       wr_addr_q;
    logic                    wr_vld_q, wr_row0_q, fwd_q, frame_err_q;

    assign in_tready  = (state_q == S_ACC);
    assign hs         = in_tvalid & in_tready;
    assign last_elem  = (col_q == DIM2 - 1'b1) && (row_q == DIM1 - 1'b1);
    assign out_tvalid = (state_q == S_OUT);
    assign out_tlast  = out_tvalid && (out_addr_q == DIM2 - 1'b1);
    assign out_tdata  = rd_q;
    assign frame_err  = frame_err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_RESET;
            flush_q    <= 1'b0;
            col_q      <= '0;
            row_q      <= '0;
            out_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            flush_q    <= flush_d;
            col_q      <= col_d;
            row_q      <= row_d;
            out_addr_q <= out_addr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        flush_d    = flush_q;
        col_d      = col_q;
        row_d      = row_q;
        out_addr_d = out_addr_q;
        rd_en      = 1'b0;
        rd_addr    = col_q[ADDR_W-1:0];
        case (state_q)
            S_RESET: begin
                state_d = S_ACC;
                col_d   = '0;
                row_d   = '0;
            end
            S_ACC: begin
                rd_en = hs;
                if (hs) begin
                    if (col_q == DIM2 - 1'b1) begin
                        col_d = '0;
                        row_d = (row_q == DIM1 - 1'b1) ? '0 : row_q + 1'b1;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                    if (last_elem) begin
                        state_d = S_FLUSH;
                        flush_d = 1'b0;
                    end
                end
            end
            S_FLUSH: begin
                // First cycle lets the final write land; second fetches element 0.
                if (!flush_q) begin
                    flush_d = 1'b1;
                end else begin
                    rd_en      = 1'b1;
                    rd_addr    = '0;
                    out_addr_d = '0;
                    state_d    = S_OUT;
                end
            end
            S_OUT: begin
                if (out_tready) begin
                    if (out_tlast) begin
                        state_d = S_ACC;
                    end else begin
                        rd_en      = 1'b1;
                        rd_addr    = ADDR_W'(out_addr_q + 1'b1);
                        out_addr_d = out_addr_q + 1'b1;
                    end
                end
            end
            default: state_d = S_RESET;
        endcase
    end

    // Old value: row 0 starts from zero; a same-address write one cycle earlier is not yet
    // visible in the registered read, so it is forwarded.
    assign old_val = wr_row0_q ? '0 : (fwd_q ? fwd_data_q : rd_q);

`ifdef SATURATE_EN
    logic [X_W:0] sum_w;
    always_comb begin
        sum_w = {old_val[X_W-1], old_val} + {wr_x_q[X_W-1], wr_x_q};
        sum   = sum_w[X_W-1:0];
        if (sum_w[X_W] != sum_w[X_W-1])
            sum = sum_w[X_W] ? {1'b1, {(X_W-1){1'b0}}} : {1'b0, {(X_W-1){1'b1}}};
    end
`else
    assign sum = old_val + wr_x_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q        <= '0;
            wr_vld_q    <= 1'b0;
            wr_row0_q   <= 1'b0;
            wr_addr_q   <= '0;
            wr_x_q      <= '0;
            fwd_q       <= 1'b0;
            fwd_data_q  <= '0;
            frame_err_q <= 1'b0;
        end else begin
            if (rd_en) rd_q <= mem[rd_addr];
            wr_vld_q    <= hs;
            wr_row0_q   <= (row_q == '0);
            wr_addr_q   <= col_q[ADDR_W-1:0];
            wr_x_q      <= {{(X_W-Y_W){in_tdata[Y_W-1]}}, in_tdata};
            fwd_q       <= wr_vld_q && (wr_addr_q == col_q[ADDR_W-1:0]);
            fwd_data_q  <= sum;
            frame_err_q <= hs && (in_tlast != last_elem);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_vld_q) mem[wr_addr_q] <= sum;
    end
endmodule

// File: tb/tb_stream_vector_accum.sv
// Table-driven scoreboard bench for stream_vector_accum, plus reset-abort and narrow-width cases.
module tb_stream_vector_accum;
    logic        clk = 1'b0, rst = 1'b1;
    logic [7:0]  in_tdata = '0;
    logic        in_tlast = 1'b0, in_tvalid = 1'b0, in_tready;
    logic [31:0] out_tdata;
    logic        out_tlast, out_tvalid, out_tready = 1'b1, frame_err;
    logic [23:0] DIM1 = 24'd1, DIM2 = 24'd1;

    logic [7:0]  i9_data = '0;
    logic        i9_valid = 1'b0, i9_ready, i9_last = 1'b0;
    logic [8:0]  o9_data;
    logic        o9_last, o9_valid, o9_err;
    logic [23:0] d9_1 = 24'd4, d9_2 = 24'd1;

    always #5 clk = ~clk;

    stream_vector_accum u_dut (
        .clk(clk), .rst(rst), .in_tdata(in_tdata), .in_tlast(in_tlast), .in_tvalid(in_tvalid),
        .in_tready(in_tready), .out_tdata(out_tdata), .out_tlast(out_tlast),
        .out_tvalid(out_tvalid), .out_tready(out_tready), .frame_err(frame_err),
        .DIM1(DIM1), .DIM2(DIM2)
    );

    stream_vector_accum #(.X_W(9), .MEM_DEPTH(16)) u_dut9 (
        .clk(clk), .rst(rst), .in_tdata(i9_data), .in_tlast(i9_last), .in_tvalid(i9_valid),
        .in_tready(i9_ready), .out_tdata(o9_data), .out_tlast(o9_last),
        .out_tvalid(o9_valid), .out_tready(1'b1), .frame_err(o9_err),
        .DIM1(d9_1), .DIM2(d9_2)
    );

    typedef struct packed { int d1; int d2; int soff; int eoff; int tlm; int nerr; bit stall; } vec_t;
    typedef struct { logic [31:0] d; bit l; } exp_t;

    vec_t tbl [7];
    int stim [43] = '{1, 2, 3, 4, 10, 20, 30, 40, -1, -2, -3, -4,
                      127, 127, 127, -128, 1,
                      1, 2, 3, 4, 5, 6,
                      1, 1, 1, 1,
                      5, 6, 7, 8,
                      -5, 100, -128, 127,
                      -128, -128, -128, -128, -128, -128, -128, -128};
    int expv [18] = '{10, 20, 30, 40, 254, 5, 7, 9, 2, 2, 12, 14, -5, 100, -128, 127, -512, -512};

    exp_t sbq [$];
    exp_t cur;
    int   tests = 0, fails = 0, beats = 0, errs = 0, cyc = 0;
    bit   stall_mode = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, req);
        end
    endtask

    always @(posedge clk) begin
        #1;
        cyc++;
        out_tready = stall_mode ? (cyc % 3 == 0) : 1'b1;
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (frame_err) errs++;
            if (out_tvalid && out_tready) begin
                if (sbq.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_beat: got data %0h, expected no output", out_tdata);
                end else begin
                    cur = sbq.pop_front();
                    chk("out_tdata", {32'd0, out_tdata}, {32'd0, cur.d});
                    chk("out_tlast", {63'd0, out_tlast}, {63'd0, cur.l});
                    beats++;
                end
            end
        end
    end

    task automatic send(input logic [7:0] d, input bit l);
        int n = 0;
        @(negedge clk);
        in_tdata = d; in_tlast = l; in_tvalid = 1'b1;
        while (!in_tready && n < 50) begin @(negedge clk); n++; end
        if (!in_tready) begin
            tests++; fails++;
            $display("FAIL send_timeout: in_tready 0, expected 1 within 50 cycles");
        end
        @(posedge clk);
        #1 in_tvalid = 1'b0;
    endtask

    task automatic push_exp(input int eoff, input int d2);
        exp_t e;
        for (int j = 0; j < d2; j++) begin
            e.d = expv[eoff + j];
            e.l = (j == d2 - 1);
            sbq.push_back(e);
        end
    endtask

    task automatic drain(input int d2, input int e0, input int nerr);
        int n = 0;
        while (sbq.size() != 0 && n < 200) begin @(negedge clk); n++; end
        repeat (2) @(negedge clk);
        chk("drain", sbq.size(), 0);
        chk("beats", beats, d2);
        chk("frame_err_count", errs - e0, nerr);
        sbq.delete();
    endtask

    initial begin
        int lat, e0, n;
        tbl[0] = '{d1: 3, d2: 4, soff: 0,  eoff: 0,  tlm: 0,  nerr: 0, stall: 1'b0};
        tbl[1] = '{d1: 5, d2: 1, soff: 12, eoff: 4,  tlm: 0,  nerr: 0, stall: 1'b0};
        tbl[2] = '{d1: 2, d2: 3, soff: 17, eoff: 5,  tlm: 0,  nerr: 0, stall: 1'b1};
        tbl[3] = '{d1: 2, d2: 2, soff: 23, eoff: 8,  tlm: 0,  nerr: 0, stall: 1'b0};
        tbl[4] = '{d1: 2, d2: 2, soff: 27, eoff: 10, tlm: 0,  nerr: 0, stall: 1'b0};
        tbl[5] = '{d1: 1, d2: 4, soff: 31, eoff: 12, tlm: 10, nerr: 1, stall: 1'b0};
        tbl[6] = '{d1: 4, d2: 2, soff: 35, eoff: 16, tlm: 0,  nerr: 0, stall: 1'b0};

        repeat (3) @(negedge clk);
        chk("rst_in_tready", in_tready, 0);
        chk("rst_out_tvalid", out_tvalid, 0);
        chk("rst_out_tlast", out_tlast, 0);
        chk("rst_frame_err", frame_err, 0);
        chk("rst_out_tdata", out_tdata, 0);
        chk("rst_o9_valid", o9_valid, 0);
        rst = 1'b0;

        for (int v = 0; v < 7; v++) begin
            DIM1 = tbl[v].d1[23:0];
            DIM2 = tbl[v].d2[23:0];
            stall_mode = tbl[v].stall;
            beats = 0;
            e0 = errs;
            push_exp(tbl[v].eoff, tbl[v].d2);
            n = tbl[v].d1 * tbl[v].d2;
            for (int i = 0; i < n; i++)
                send(8'(stim[tbl[v].soff + i]), (tbl[v].tlm == 0) ? (i == n - 1) : tbl[v].tlm[i]);
            lat = 0;
            do begin @(negedge clk); lat++; end while (!out_tvalid && lat < 20);
            chk("latency", lat, 3);
            chk("in_tready_during_out", in_tready, 0);
            drain(tbl[v].d2, e0, tbl[v].nerr);
            stall_mode = 1'b0;
        end

        // Abort a partly accumulated matrix with reset, then run a fresh one.
        DIM1 = 24'd2; DIM2 = 24'd2;
        send(8'd9, 1'b0);
        send(8'd9, 1'b0);
        @(negedge clk) rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_in_tready", in_tready, 0);
        chk("mid_rst_out_tvalid", out_tvalid, 0);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        beats = 0;
        e0 = errs;
        begin
            exp_t e;
            e.d = 32'd8;  e.l = 1'b0; sbq.push_back(e);
            e.d = 32'd10; e.l = 1'b1; sbq.push_back(e);
        end
        send(8'd3, 1'b0); send(8'd4, 1'b0); send(8'd5, 1'b0); send(8'd6, 1'b1);
        drain(2, e0, 0);

        // Narrow accumulator: 4 x 127 overflows 9 bits.
        for (int i = 0; i < 4; i++) begin
            n = 0;
            @(negedge clk);
            i9_data = 8'd127; i9_last = (i == 3); i9_valid = 1'b1;
            while (!i9_ready && n < 50) begin @(negedge clk); n++; end
            @(posedge clk);
            #1 i9_valid = 1'b0;
        end
        n = 0;
        while (!o9_valid && n < 20) begin @(negedge clk); n++; end
        chk("x9_valid", o9_valid, 1);
`ifdef SATURATE_EN
        chk("x9_sum", o9_data, 9'h0FF);
`else
        chk("x9_sum", o9_data, 9'h1FC);
`endif
        chk("x9_tlast", o9_last, 1);
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
